// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between an instruction reader (I) and a data requester (D).
// D has fixed priority; a streak counter lets I win after STREAK back-to-back D grants
// that happened while I was waiting. Each access holds the bus for ACC_CYC cycles.
module sram_port_arbiter #(
  parameter int unsigned AW      = 20,
  parameter int unsigned DW      = 32,
  parameter int unsigned ACC_CYC = 2,
  parameter int unsigned STREAK  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_wmask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          sram_en,
  output logic          sram_we,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          busy
);

  localparam int unsigned CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam int unsigned SW = $clog2(STREAK + 1);
  localparam logic [CW-1:0] CntLast   = CW'(ACC_CYC - 1);
  localparam logic [SW-1:0] StreakMax = SW'(STREAK);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic          cmd_is_d;  // owner of the access in flight

  logic last;
  logic acc;
  logic starve;

  // Grants are combinational so a new access can start in the last cycle of the previous one.
  assign last   = (state == StAccess) && (cnt == CntLast);
  assign acc    = (state == StIdle) || last;
  assign starve = i_req && (streak == StreakMax);
  assign d_gnt  = acc && d_req && !starve;
  assign i_gnt  = acc && i_req && !d_gnt;
  assign busy   = (state == StAccess);

  // FSM, command/SRAM output registers, completion capture and streak tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      streak     <= '0;
      cmd_is_d   <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      i_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;

      // Completion: read data is valid in the last access cycle.
      if (last) begin
        if (cmd_is_d) begin
          d_rvalid <= 1'b1;
          if (!sram_we) begin
            d_rdata <= sram_dout;
          end
        end else begin
          i_rvalid <= 1'b1;
          i_rdata  <= sram_dout;
        end
      end

      if (d_gnt) begin
        state      <= StAccess;
        cnt        <= '0;
        cmd_is_d   <= 1'b1;
        sram_en    <= 1'b1;
        sram_we    <= d_we;
        sram_wmask <= d_we ? d_wmask : 4'hf;
        sram_addr  <= d_addr;
        sram_din   <= d_wdata;
      end else if (i_gnt) begin
        state      <= StAccess;
        cnt        <= '0;
        cmd_is_d   <= 1'b0;
        sram_en    <= 1'b1;
        sram_we    <= 1'b0;
        sram_wmask <= 4'hf;
        sram_addr  <= i_addr;
        sram_din   <= '0;
      end else if (last) begin
        state      <= StIdle;
        cnt        <= '0;
        cmd_is_d   <= 1'b0;
        sram_en    <= 1'b0;
        sram_we    <= 1'b0;
        sram_wmask <= '0;
        sram_addr  <= '0;
        sram_din   <= '0;
      end else if (state == StAccess) begin
        cnt <= cnt + CW'(1);
      end

      // Only D grants that make a waiting I wait longer add to the streak.
      if (d_gnt && i_req) begin
        if (streak != StreakMax) begin
          streak <= streak + SW'(1);
        end
      end else if (i_gnt || !i_req) begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter: a transaction-level model predicts grants,
// bus contents and completions, and a bench-side SRAM plus a reference memory check data.
module tb_sram_port_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned ACC = 2;
  localparam int unsigned STRK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [3:0]    d_wmask = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          sram_en, sram_we, busy;
  logic [3:0]    sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  // Second instance with single-cycle accesses, D side only.
  logic          b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
  logic [DW-1:0] b_i_rdata, b_d_rdata, b_sram_din, b_sram_dout;
  logic          b_d_req = 1'b0;
  logic [AW-1:0] b_d_addr = '0;
  logic          b_sram_en, b_sram_we, b_busy;
  logic [3:0]    b_sram_wmask;
  logic [AW-1:0] b_sram_addr;

  always #5 clk = ~clk;

  sram_port_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(ACC), .STREAK(STRK)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy)
  );

  sram_port_arbiter #(.AW(AW), .DW(DW), .ACC_CYC(1), .STREAK(STRK)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(1'b0), .i_addr('0), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(1'b0), .d_wmask(4'h0), .d_addr(b_d_addr), .d_wdata('0),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_wmask(b_sram_wmask),
    .sram_addr(b_sram_addr), .sram_din(b_sram_din), .sram_dout(b_sram_dout), .busy(b_busy)
  );

  assign b_sram_dout = {12'hA5A, b_sram_addr};

  // Bench-side SRAM, 16 words indexed by the low address bits.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  logic          mem_init = 1'b1;

  function automatic logic [DW-1:0] seed_word(input int k);
    return 32'hC0DE_F00D ^ (32'h1357_9BDF * k);
  endfunction

  assign sram_dout = sram_en ? mem[sram_addr[3:0]] : '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 16; k++) mem[k] <= seed_word(k);
    end else if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wmask[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_din[8*b +: 8];
      end
    end
  end

  int nchecks = 0;
  int nfail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining bus cycles of the current access, its owner and command.
  int            busy_left;
  int            streak;
  logic          cur_d, cur_we;
  logic [3:0]    cur_mask;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic          e_irv, e_drv, e_ig, e_dg;
  logic [DW-1:0] e_irdata, e_drdata;

  task automatic model_reset();
    busy_left = 0; streak = 0;
    cur_d = 1'b0; cur_we = 1'b0; cur_mask = '0; cur_addr = '0; cur_wdata = '0;
    e_irv = 1'b0; e_drv = 1'b0; e_ig = 1'b0; e_dg = 1'b0;
    e_irdata = '0; e_drdata = '0;
  endtask

  task automatic check_cycle();
    logic acc;
    acc  = (busy_left <= 1);
    e_dg = acc && d_req && !(i_req && streak == int'(STRK));
    e_ig = acc && i_req && !e_dg;
    check_eq("i_gnt", i_gnt, e_ig);
    check_eq("d_gnt", d_gnt, e_dg);
    check_eq("busy", busy, busy_left > 0);
    check_eq("sram_en", sram_en, busy_left > 0);
    if (busy_left > 0) begin
      check_eq("sram_we", sram_we, cur_we);
      check_eq("sram_wmask", sram_wmask, cur_we ? cur_mask : 4'hf);
      check_eq("sram_addr", sram_addr, cur_addr);
      check_eq("sram_din", sram_din, cur_wdata);
    end else begin
      check_eq("sram_idle", {sram_we, sram_wmask, sram_addr, sram_din}, '0);
    end
    check_eq("i_rvalid", i_rvalid, e_irv);
    check_eq("d_rvalid", d_rvalid, e_drv);
    check_eq("i_rdata", i_rdata, e_irdata);
    check_eq("d_rdata", d_rdata, e_drdata);
  endtask

  task automatic model_step();
    logic nirv, ndrv;
    nirv = 1'b0;
    ndrv = 1'b0;
    if (busy_left == 1) begin
      if (cur_d) begin
        ndrv = 1'b1;
        if (cur_we) begin
          for (int b = 0; b < 4; b++) begin
            if (cur_mask[b]) ref_mem[cur_addr[3:0]][8*b +: 8] = cur_wdata[8*b +: 8];
          end
        end else begin
          e_drdata = ref_mem[cur_addr[3:0]];
        end
      end else begin
        nirv = 1'b1;
        e_irdata = ref_mem[cur_addr[3:0]];
      end
    end
    if (e_dg && i_req) streak = (streak < int'(STRK)) ? streak + 1 : int'(STRK);
    else if (e_ig || !i_req) streak = 0;
    if (e_dg) begin
      cur_d = 1'b1; cur_we = d_we; cur_mask = d_wmask; cur_addr = d_addr; cur_wdata = d_wdata;
      busy_left = ACC;
    end else if (e_ig) begin
      cur_d = 1'b0; cur_we = 1'b0; cur_mask = 4'hf; cur_addr = i_addr; cur_wdata = '0;
      busy_left = ACC;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    e_irv = nirv;
    e_drv = ndrv;
  endtask

  // Requests are held until granted; a new one may follow right after the grant.
  task automatic run_random(input int n, input bit gen);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!i_req || e_ig) begin
        if (gen && $urandom_range(3) != 0) begin
          i_req = 1'b1; i_addr = AW'($urandom);
        end else begin
          i_req = 1'b0;
        end
      end
      if (!d_req || e_dg) begin
        if (gen && $urandom_range(3) != 0) begin
          d_req = 1'b1; d_we = 1'($urandom_range(1)); d_wmask = 4'($urandom);
          d_addr = AW'($urandom); d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end
      #1;
      check_cycle();
      model_step();
    end
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 16; k++) ref_mem[k] = seed_word(k);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_sram_en", sram_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sram_bus", {sram_we, sram_wmask, sram_addr, sram_din}, '0);
    check_eq("rst_rdata", {i_rdata, d_rdata}, '0);
    check_eq("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    mem_init = 1'b0;

    run_random(600, 1'b1);
    run_random(12, 1'b0);

    // Reset in the second cycle of a D read: abandoned, no completion afterwards.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00100;
    #1 check_eq("rst_t0_dgnt", d_gnt, 1'b1);
    @(negedge clk);
    d_req = 1'b0;
    #1 check_eq("rst_t1_en", sram_en, 1'b1);
    @(posedge clk);
    #1 check_eq("rst_t2_en", sram_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_en", sram_en, 1'b0);
    check_eq("rst_async_busy", busy, 1'b0);
    check_eq("rst_async_addr", sram_addr, '0);
    check_eq("rst_async_rdata", {i_rdata, d_rdata}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check_eq("rst_no_rvalid", d_rvalid, 1'b0);
    end

    run_random(300, 1'b1);
    run_random(12, 1'b0);

    // Single-cycle accesses: eight back-to-back D reads, one completion per cycle.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        b_d_req = 1'b1; b_d_addr = AW'(20'h00300 + k);
      end else begin
        b_d_req = 1'b0;
      end
      #1;
      if (k < 8) check_eq("b2b_gnt", b_d_gnt, 1'b1);
      check_eq("b2b_en", b_sram_en, (k >= 1) && (k <= 8));
      if (k >= 1 && k <= 8) check_eq("b2b_addr", b_sram_addr, AW'(20'h00300 + k - 1));
      check_eq("b2b_rvalid", b_d_rvalid, k >= 2);
      if (k >= 2) check_eq("b2b_rdata", b_d_rdata, {12'hA5A, AW'(20'h00300 + k - 2)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
